dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the single-port data SRAM.
- Shares the SRAM between port 0 (CPU load/store path) and port 1 (loader/DMA/debug requester).
- Latches one request at a time, drives the SRAM enables for exactly one cycle, waits out the read latency and returns read data to the winning requester.
- Sits between the core's memory-stage signals and the sram instance in top.

---
 rtl/dmem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer in front of the single-port data SRAM.
// Port 0 is the CPU load/store path, port 1 the loader/DMA/debug requester.
// One request is latched at a time; the SRAM enable is driven for exactly one
// cycle, the read latency is waited out and the read word is returned to the
// port that won. Every output comes straight from a flop.

module dmem_arbiter #(
  parameter int N          = 32,
  parameter int RD_LAT     = 1,   // SRAM read latency in cycles, 0..7
  parameter int FIXED_PRIO = 0    // 0: round-robin on ties, 1: port 0 wins ties
) (
  input  logic         clk,
  input  logic         rstn,

  input  logic         req0,
  input  logic         we0,
  input  logic [N-1:0] addr0,
  input  logic [N-1:0] wdata0,
  output logic         gnt0,
  output logic         rvalid0,
  output logic [N-1:0] rdata0,

  input  logic         req1,
  input  logic         we1,
  input  logic [N-1:0] addr1,
  input  logic [N-1:0] wdata1,
  output logic         gnt1,
  output logic         rvalid1,
  output logic [N-1:0] rdata1,

  output logic         mem_write_enable,
  output logic         mem_read_enable,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_data_in,
  input  logic [N-1:0] mem_data_out,

  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // Counter load value for the WAIT state; RD_LAT never exceeds 7.
  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t       state;
  logic         last_grant;  // port that received the most recent grant
  logic         cur_port;    // port owning the transaction in flight
  logic         cur_we;      // transaction in flight is a write
  logic [2:0]   cnt;         // remaining read-latency cycles while in WAIT

  logic         win;
  logic         win_we;
  logic [N-1:0] win_addr;
  logic [N-1:0] win_wdata;

  // Arbitration for the IDLE cycle: a lone requester wins; a tie goes to
  // port 0 under fixed priority, otherwise to the port that did not win last.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    win = 1'b0;
    if (req0 && req1) begin
      win = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end else if (req1) begin
      win = 1'b1;
    end
    win_we    = win ? we1    : we0;
    win_addr  = win ? addr1  : addr0;
    win_wdata = win ? wdata1 : wdata0;
  end

  // Transaction sequencer: latch in IDLE, pulse enables and grant in ACCESS,
  // count out the read latency in WAIT, capture and return the read word.
  always_ff @(posedge clk) begin
    // NOTE: rstn is sampled on the clock edge like any other input, so reset
    // here is synchronous; it also aborts a transaction in flight.
    if (!rstn) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      cur_port         <= 1'b0;
      cur_we           <= 1'b0;
      cnt              <= '0;
      gnt0             <= 1'b0;
      gnt1             <= 1'b0;
      rvalid0          <= 1'b0;
      rvalid1          <= 1'b0;
      rdata0           <= '0;
      rdata1           <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_addr         <= '0;
      mem_data_in      <= '0;
      busy             <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop in
      // this block samples the pre-edge values, matching the hardware.
      // Pulse outputs default low; only the branches below raise them.
      gnt0             <= 1'b0;
      gnt1             <= 1'b0;
      rvalid0          <= 1'b0;
      rvalid1          <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;

      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state            <= ACCESS;
            busy             <= 1'b1;
            cur_port         <= win;
            cur_we           <= win_we;
            last_grant       <= win;
            mem_addr         <= win_addr;
            mem_data_in      <= win_wdata;
            gnt0             <= ~win;
            gnt1             <= win;
            mem_write_enable <= win_we;
            mem_read_enable  <= ~win_we;
          end
        end

        ACCESS: begin
          if (cur_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (RD_LAT == 0) begin
            // Zero-latency SRAM: the word is valid during the enable cycle.
            state <= IDLE;
            busy  <= 1'b0;
            if (cur_port) begin
              rdata1  <= mem_data_out;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= mem_data_out;
              rvalid0 <= 1'b1;
            end
          end else begin
            state <= WAIT;
            cnt   <= LAT;
          end
        end

        WAIT: begin
          if (cnt == 3'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (cur_port) begin
              rdata1  <= mem_data_out;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= mem_data_out;
              rvalid0 <= 1'b1;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the sequencer.
  a_gnt_excl: assert property (@(posedge clk) disable iff (!rstn)
    !(gnt0 && gnt1));
  a_rvalid_excl: assert property (@(posedge clk) disable iff (!rstn)
    !(rvalid0 && rvalid1));
  a_en_excl: assert property (@(posedge clk) disable iff (!rstn)
    !(mem_write_enable && mem_read_enable));
  a_en_in_access: assert property (@(posedge clk) disable iff (!rstn)
    (mem_write_enable || mem_read_enable) |-> (state == ACCESS));

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: four dmem_arbiter instances in different configurations
// (RD_LAT/FIXED_PRIO = 1/0, 0/0, 3/0, 1/1), each with its own SRAM model,
// a transaction-timeline reference model, a per-cycle compare process,
// directed literal checks and randomized two-port traffic.

module tb_dmem_arbiter;

  localparam int NCFG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input int cfg, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cfg%0d %s actual=%h required=%h", cfg, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int L  = (g == 1) ? 0 : (g == 2) ? 3 : 1;
    localparam int FP = (g == 3) ? 1 : 0;

    logic        rstn;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, rvalid0, gnt1, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_write_enable, mem_read_enable;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;
    logic        busy;
    bit          fin = 1'b0;

    dmem_arbiter #(.N(32), .RD_LAT(L), .FIXED_PRIO(FP)) dut (
      .clk(clk), .rstn(rstn),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .busy(busy)
    );

    // ---------------- SRAM model: 64 words, read latency L ----------------
    logic [31:0]      sram [64];
    logic [7:0][31:0] pipe;
    logic [31:0]      junk;

    initial sram <= '{default: '0};

    always @(posedge clk) begin
      junk <= $urandom;
      if (mem_write_enable) sram[mem_addr[5:0]] <= mem_data_in;
      pipe <= {pipe[6:0], (mem_read_enable ? sram[mem_addr[5:0]] : junk)};
    end

    if (L == 0) begin : g_comb
      assign mem_data_out = mem_read_enable ? sram[mem_addr[5:0]] : junk;
    end else begin : g_pipe
      assign mem_data_out = pipe[L-1];
    end

    // ---------------- Reference model: transaction timeline ----------------
    // Each accepted request books its gnt/enable cycle, its rvalid cycle and
    // the cycle the arbiter becomes free again; outputs are read off the book.
    bit [15:0]   rg0 = '0, rg1 = '0, rwe = '0, rre = '0, rrv0 = '0, rrv1 = '0;
    logic [31:0] rdat [16];
    logic [31:0] ref_mem [64];
    int          cyc = 0;
    int          free_at = 0;
    bit          lastg = 1'b1;
    logic [31:0] e_addr = '0, e_din = '0, e_rd0 = '0, e_rd1 = '0;
    bit          armed = 1'b0;

    initial begin
      logic [3:0]  s, n, k;
      bit          w, mwe;
      logic [31:0] ma, md;
      ref_mem = '{default: '0};
      forever begin
        @(posedge clk);
        s = 4'(cyc);
        rg0[s] = 1'b0; rg1[s] = 1'b0; rwe[s] = 1'b0; rre[s] = 1'b0;
        rrv0[s] = 1'b0; rrv1[s] = 1'b0;
        if (!rstn) begin
          rg0 = '0; rg1 = '0; rwe = '0; rre = '0; rrv0 = '0; rrv1 = '0;
          free_at = cyc + 1;
          lastg = 1'b1;
          e_addr = '0; e_din = '0; e_rd0 = '0; e_rd1 = '0;
        end else if (cyc >= free_at && (req0 || req1)) begin
          if (req0 && req1) w = (FP != 0) ? 1'b0 : ~lastg;
          else              w = req1;
          lastg  = w;
          mwe    = w ? we1 : we0;
          ma     = w ? addr1 : addr0;
          md     = w ? wdata1 : wdata0;
          e_addr = ma;
          e_din  = md;
          n = 4'(cyc + 1);
          if (w) rg1[n] = 1'b1; else rg0[n] = 1'b1;
          if (mwe) begin
            rwe[n] = 1'b1;
            ref_mem[ma[5:0]] = md;
            free_at = cyc + 2;
          end else begin
            rre[n] = 1'b1;
            k = 4'(cyc + 2 + L);
            if (w) rrv1[k] = 1'b1; else rrv0[k] = 1'b1;
            rdat[k] = ref_mem[ma[5:0]];
            free_at = cyc + 2 + L;
          end
        end
        cyc++;
        s = 4'(cyc);
        if (rrv0[s]) e_rd0 = rdat[s];
        if (rrv1[s]) e_rd1 = rdat[s];
        armed = 1'b1;
      end
    end

    // ---------------- Per-cycle compare against the model ----------------
    initial begin
      forever begin
        @(negedge clk);
        if (armed) begin
          logic [3:0] s;
          s = 4'(cyc);
          check(g, "gnt0",       32'(gnt0),             32'(rg0[s]));
          check(g, "gnt1",       32'(gnt1),             32'(rg1[s]));
          check(g, "mem_we",     32'(mem_write_enable), 32'(rwe[s]));
          check(g, "mem_re",     32'(mem_read_enable),  32'(rre[s]));
          check(g, "rvalid0",    32'(rvalid0),          32'(rrv0[s]));
          check(g, "rvalid1",    32'(rvalid1),          32'(rrv1[s]));
          check(g, "busy",       32'(busy),             32'(cyc < free_at));
          check(g, "mem_addr",   mem_addr,              e_addr);
          check(g, "mem_din",    mem_data_in,           e_din);
          check(g, "rdata0",     rdata0,                e_rd0);
          check(g, "rdata1",     rdata1,                e_rd1);
          check(g, "excl_gnt",   32'(gnt0 & gnt1),      32'd0);
          check(g, "excl_rv",    32'(rvalid0 & rvalid1), 32'd0);
          check(g, "excl_en",    32'(mem_write_enable & mem_read_enable), 32'd0);
        end
      end
    end

    // ---------------- Stimulus ----------------
    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic do_read(input bit p, input logic [31:0] a, input logic [31:0] exp);
      if (p) begin req1 = 1'b1; we1 = 1'b0; addr1 = a; end
      else   begin req0 = 1'b1; we0 = 1'b0; addr0 = a; end
      step();
      check(g, "rd_gnt", 32'(p ? gnt1 : gnt0), 32'd1);
      check(g, "rd_re",  32'(mem_read_enable), 32'd1);
      req0 = 1'b0;
      req1 = 1'b0;
      for (int c = 2; c <= 2 + L; c++) begin
        step();
        check(g, "rd_rvalid_time", 32'(p ? rvalid1 : rvalid0), 32'(c == 2 + L));
      end
      check(g, "rd_data",         p ? rdata1 : rdata0,            exp);
      check(g, "rd_other_rvalid", 32'(p ? rvalid0 : rvalid1),     32'd0);
    endtask

    initial begin
      int grants, budget;
      rstn = 1'b0;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      repeat (3) step();
      rstn = 1'b1;
      step();

      // Reset state.
      check(g, "rst_busy",   32'(busy),    32'd0);
      check(g, "rst_rdata0", rdata0,       32'd0);
      check(g, "rst_addr",   mem_addr,     32'd0);

      // Port 0 write 0x10 <- DEADBEEF.
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF;
      step();
      check(g, "wr_gnt0",  32'(gnt0),             32'd1);
      check(g, "wr_we",    32'(mem_write_enable), 32'd1);
      check(g, "wr_addr",  mem_addr,              32'h10);
      check(g, "wr_din",   mem_data_in,           32'hDEAD_BEEF);
      req0 = 1'b0;
      step();
      check(g, "wr_busy_done", 32'(busy),             32'd0);
      check(g, "wr_we_once",   32'(mem_write_enable), 32'd0);
      step();

      // Port 1 read of the same word; port 0 read data untouched.
      do_read(1'b1, 32'h10, 32'hDEAD_BEEF);
      check(g, "rd_rdata0_kept", rdata0, 32'd0);
      step();
      step();

      // Both ports continuously requesting writes.
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h1111_1111;
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h21; wdata1 = 32'h2222_2222;
      for (int c = 1; c <= 5; c++) begin
        step();
        if (c % 2 == 1) begin
          check(g, "tie_gnt0", 32'(gnt0), (c == 3) ? 32'(FP != 0) : 32'd1);
          check(g, "tie_gnt1", 32'(gnt1), (c == 3) ? 32'(FP == 0) : 32'd0);
        end
      end
      step();
      req0 = 1'b0;
      req1 = 1'b0;
      step();
      step();

      // Port 0 read completes, then a second one is cut by reset mid-flight.
      do_read(1'b0, 32'h10, 32'hDEAD_BEEF);
      step();
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
      step();
      check(g, "abort_gnt0", 32'(gnt0), 32'd1);
      req0 = 1'b0;
      repeat ((L > 0) ? 1 : 0) step();
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      check(g, "abort_busy",   32'(busy),    32'd0);
      check(g, "abort_rdata0", rdata0,       32'd0);
      check(g, "abort_rdata1", rdata1,       32'd0);
      repeat (8) begin
        step();
        check(g, "abort_no_rvalid0", 32'(rvalid0), 32'd0);
      end
      do_read(1'b0, 32'h10, 32'hDEAD_BEEF);
      step();

      // Randomized two-port traffic.
      grants = 0;
      budget = 0;
      while (grants < 260 && budget < 6000) begin
        step();
        budget++;
        if (gnt0) begin grants++; req0 = 1'b0; end
        if (gnt1) begin grants++; req1 = 1'b0; end
        if (req0 && $urandom_range(0, 99) < 3) req0 = 1'b0;
        if (req1 && $urandom_range(0, 99) < 3) req1 = 1'b0;
        if (!req0 && $urandom_range(0, 99) < 60) begin
          req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
          addr0 = 32'($urandom_range(0, 63)); wdata0 = $urandom;
        end
        if (!req1 && $urandom_range(0, 99) < 60) begin
          req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
          addr1 = 32'($urandom_range(0, 63)); wdata1 = $urandom;
        end
      end
      check(g, "rand_progress", 32'(grants >= 260), 32'd1);
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (12) step();
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin) && t < 40000) begin
      @(posedge clk);
      t++;
    end
    check(-1, "finish_in_budget", 32'(t < 40000), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
